// File: rtl/eth_rx_mem_writer.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_mem_writer
// Brief    : Packs an RX byte stream into 32-bit words and feeds them to the
//            SDRAM write port, reporting each frame's base address and length.
// Revision : 1.0
// ============================================================================
module eth_rx_mem_writer #(
    parameter logic [18:0] BASE_AD    = 19'd0,
    parameter int          FIFO_DEPTH = 8,
    parameter int          WR_HOLD    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        wr_req,
    output logic [18:0] wr_ad,
    output logic [31:0] wr_data,
    input  logic        wr_granted,
    output logic        frame_done,
    output logic [18:0] frame_base,
    output logic [15:0] frame_len,
    output logic        busy
);

    localparam int c_AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int c_HW = (WR_HOLD < 2) ? 1 : $clog2(WR_HOLD + 1);
    localparam int c_EW = 36;
    localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_HW-1:0] c_HOLD_LOAD = c_HW'(WR_HOLD);
    localparam logic [c_HW-1:0] c_HOLD_ONE  = c_HW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    logic [31:0]     r_pack_data;
    logic [1:0]      r_pack_cnt;
    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_avail;
    logic            r_in_ready;
    logic [1:0]      r_state;
    logic [c_HW-1:0] r_hold;
    logic [18:0]     r_next_ad;
    logic [18:0]     r_base_acc;
    logic [15:0]     r_len_acc;
    logic            r_first;
    logic            r_cur_last;
    logic [2:0]      r_cur_nbytes;
    logic            r_wr_req;
    logic [18:0]     r_wr_ad;
    logic [31:0]     r_wr_data;
    logic            r_frame_done;
    logic [18:0]     r_frame_base;
    logic [15:0]     r_frame_len;

    logic            w_accept;
    logic [31:0]     w_word;
    logic            w_push;
    logic            w_pop;
    logic [c_EW-1:0] w_push_entry;
    logic [c_EW-1:0] w_head;
    logic [c_AW:0]   w_count_next;
    logic [16:0]     w_len_sum;
    logic [15:0]     w_len_sat;

    assign w_accept     = in_valid && r_in_ready;
    assign w_word       = r_pack_data | ({24'd0, in_data} << {r_pack_cnt, 3'b000});
    // The 4th byte and in_last may coincide: still exactly one push.
    assign w_push       = w_accept && (in_last || (r_pack_cnt == 2'd3));
    assign w_push_entry = {in_last, {1'b0, r_pack_cnt} + 3'd1, w_word};
    assign w_pop        = (r_state == c_ST_REQ) && wr_granted;
    assign w_count_next = r_count + {{c_AW{1'b0}}, w_push} - {{c_AW{1'b0}}, w_pop};
    assign w_head       = r_mem[r_rd_ptr];
    assign w_len_sum    = {1'b0, r_len_acc} + {14'd0, r_cur_nbytes};
    assign w_len_sat    = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack_data <= 32'd0;
            r_pack_cnt  <= 2'd0;
        end else if (w_accept) begin
            if (w_push) begin
                r_pack_data <= 32'd0;
                r_pack_cnt  <= 2'd0;
            end else begin
                r_pack_data <= w_word;
                r_pack_cnt  <= r_pack_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    // r_avail trails the count by one edge, giving the two-edge request latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_avail    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_next;
            r_avail    <= (r_count != '0);
            r_in_ready <= (w_count_next < c_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_hold       <= '0;
            r_next_ad    <= BASE_AD;
            r_base_acc   <= BASE_AD;
            r_len_acc    <= 16'd0;
            r_first      <= 1'b1;
            r_cur_last   <= 1'b0;
            r_cur_nbytes <= 3'd0;
            r_wr_req     <= 1'b0;
            r_wr_ad      <= BASE_AD;
            r_wr_data    <= 32'd0;
            r_frame_done <= 1'b0;
            r_frame_base <= BASE_AD;
            r_frame_len  <= 16'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (r_avail) begin
                        r_wr_req     <= 1'b1;
                        r_wr_ad      <= r_next_ad;
                        r_wr_data    <= w_head[31:0];
                        r_cur_nbytes <= w_head[34:32];
                        r_cur_last   <= w_head[35];
                        r_state      <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    if (wr_granted) begin
                        r_wr_req  <= 1'b0;
                        r_next_ad <= r_next_ad + 19'd1;
                        r_hold    <= c_HOLD_LOAD;
                        r_len_acc <= w_len_sat;
                        if (r_first) r_base_acc <= r_wr_ad;
                        r_first   <= r_cur_last;
                        r_state   <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (r_hold > c_HOLD_ONE) begin
                        r_hold <= r_hold - c_HOLD_ONE;
                    end else begin
                        r_hold  <= '0;
                        r_state <= c_ST_IDLE;
                        if (r_cur_last) begin
                            r_frame_done <= 1'b1;
                            r_frame_base <= r_base_acc;
                            r_frame_len  <= r_len_acc;
                            r_len_acc    <= 16'd0;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign wr_req     = r_wr_req;
    assign wr_ad      = r_wr_ad;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign frame_base = r_frame_base;
    assign frame_len  = r_frame_len;
    assign busy       = (r_count != '0) || (r_pack_cnt != 2'd0) || (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_mem_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_mem_writer
// Brief    : Scoreboard bench: byte frames in, expected words/frames queued
//            from a frame-level model, monitor compares what the DUT writes.
// Revision : 1.0
// ============================================================================
module tb_eth_rx_mem_writer;

    localparam int WR_HOLD    = 4;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  in_data;
    logic        wr_req, wr_granted, frame_done, busy;
    logic [18:0] wr_ad, frame_base;
    logic [31:0] wr_data;
    logic [15:0] frame_len;

    logic        x_in_valid, x_in_last, x_in_ready;
    logic [7:0]  x_in_data;
    logic        x_wr_req, x_wr_granted, x_frame_done, x_busy;
    logic [18:0] x_wr_ad, x_frame_base;
    logic [31:0] x_wr_data;
    logic [15:0] x_frame_len;

    always #5 clk = ~clk;

    eth_rx_mem_writer #(.BASE_AD(19'd0), .FIFO_DEPTH(FIFO_DEPTH), .WR_HOLD(WR_HOLD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .wr_req(wr_req), .wr_ad(wr_ad), .wr_data(wr_data),
        .wr_granted(wr_granted), .frame_done(frame_done), .frame_base(frame_base),
        .frame_len(frame_len), .busy(busy));

    eth_rx_mem_writer #(.BASE_AD(19'h7FFFF), .FIFO_DEPTH(FIFO_DEPTH), .WR_HOLD(WR_HOLD)) dut_w (
        .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_data(x_in_data), .in_last(x_in_last),
        .in_ready(x_in_ready), .wr_req(x_wr_req), .wr_ad(x_wr_ad), .wr_data(x_wr_data),
        .wr_granted(x_wr_granted), .frame_done(x_frame_done), .frame_base(x_frame_base),
        .frame_len(x_frame_len), .busy(x_busy));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int last_grant_edge = 0;
    int bytes_sent = 0;
    bit grant_en = 1'b1;

    logic [18:0] model_next_ad;
    logic [7:0]  frame_bytes[$];
    logic [50:0] exp_words[$];
    logic [34:0] exp_frames[$];
    logic [50:0] x_seen[$];
    logic [34:0] x_frm[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: little-endian words, zero padded, sequential addresses.
    task automatic model_frame();
        int n;
        logic [31:0] w;
        n = frame_bytes.size();
        exp_frames.push_back({model_next_ad, (n > 65535) ? 16'hFFFF : 16'(n)});
        for (int i = 0; i < n; i += 4) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++)
                if (i + k < n) w[8*k +: 8] = frame_bytes[i + k];
            exp_words.push_back({model_next_ad, w});
            model_next_ad = model_next_ad + 19'd1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
        int tries;
        tries = 0;
        in_valid = 1'b1; in_data = b; in_last = last;
        while (!in_ready && tries < 2000) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 2000) check("in_ready_timeout", 1, 0);
        @(negedge clk);
        bytes_sent++;
        in_valid = 1'b0; in_last = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
    endtask

    task automatic send_frame(input bit gaps);
        model_frame();
        for (int i = 0; i < frame_bytes.size(); i++)
            send_byte(frame_bytes[i], i == frame_bytes.size() - 1, gaps);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_words.size() != 0 || exp_frames.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 64'(t >= 3000), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_next_ad = 19'd0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Grant driver for the main DUT: random delay per request, gated by grant_en.
    initial begin
        int gwait, gtarget;
        gwait = 0; gtarget = 3;
        wr_granted = 1'b0;
        forever begin
            @(negedge clk);
            wr_granted = 1'b0;
            if (!rst && wr_req && grant_en) begin
                if (gwait >= gtarget) begin
                    wr_granted = 1'b1;
                    last_grant_edge = cyc + 1;
                    gwait = 0;
                    gtarget = $urandom_range(0, 5);
                end else begin
                    gwait++;
                end
            end
        end
    end

    // Monitor / scoreboard for the main DUT.
    logic        in_req = 1'b0;
    logic [50:0] cur_exp;
    logic [34:0] frm_exp;
    always @(negedge clk) begin
        if (rst) begin
            in_req = 1'b0;
        end else begin
            if (wr_req) begin
                if (!in_req) begin
                    if (exp_words.size() == 0) begin
                        check("unexpected_wr_req", 1, 0);
                        cur_exp = {wr_ad, wr_data};
                    end else begin
                        cur_exp = exp_words.pop_front();
                        check("wr_ad", wr_ad, cur_exp[50:32]);
                        check("wr_data", wr_data, cur_exp[31:0]);
                    end
                    in_req = 1'b1;
                end else begin
                    check("wr_ad_stable", wr_ad, cur_exp[50:32]);
                    check("wr_data_stable", wr_data, cur_exp[31:0]);
                end
            end else begin
                in_req = 1'b0;
            end
            if (frame_done) begin
                if (exp_frames.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    frm_exp = exp_frames.pop_front();
                    check("frame_base", frame_base, frm_exp[34:16]);
                    check("frame_len", frame_len, frm_exp[15:0]);
                    check("frame_done_delay", cyc - last_grant_edge, WR_HOLD);
                end
            end
        end
    end

    // Grant driver and capture for the wrap-around instance.
    initial begin
        x_wr_granted = 1'b0;
        forever begin
            @(negedge clk);
            x_wr_granted = !rst && x_wr_req && !x_wr_granted;
            if (x_wr_granted) x_seen.push_back({x_wr_ad, x_wr_data});
            if (!rst && x_frame_done) x_frm.push_back({x_frame_base, x_frame_len});
        end
    end

    initial begin
        bit saw_req;
        int t;
        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
        x_in_valid = 1'b0; x_in_data = 8'd0; x_in_last = 1'b0;
        model_next_ad = 19'd0;
        repeat (3) @(negedge clk);

        check("rst_wr_req", wr_req, 0);
        check("rst_wr_ad", wr_ad, 19'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_base", frame_base, 19'd0);
        check("rst_frame_len", frame_len, 16'd0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wrap_wr_ad", x_wr_ad, 19'h7FFFF);
        check("rst_wrap_frame_base", x_frame_base, 19'h7FFFF);
        rst = 1'b0;

        frame_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(1'b0);
        drain();

        do_reset();
        frame_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(1'b1);
        drain();

        do_reset();
        frame_bytes.delete();
        for (int i = 0; i < 5; i++) frame_bytes.push_back(8'($urandom));
        send_frame(1'b0);
        frame_bytes.delete();
        for (int i = 0; i < 8; i++) frame_bytes.push_back(8'($urandom));
        send_frame(1'b0);
        drain();

        // Grant withheld long enough to fill the FIFO.
        do_reset();
        grant_en = 1'b0;
        bytes_sent = 0;
        frame_bytes.delete();
        for (int i = 0; i < 40; i++) frame_bytes.push_back(8'($urandom));
        fork
            send_frame(1'b0);
            begin
                repeat (50) @(negedge clk);
                check("bytes_before_full", bytes_sent, 4 * FIFO_DEPTH);
                check("in_ready_full", in_ready, 0);
                check("wr_req_while_withheld", wr_req, 1);
                grant_en = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a frame drops the partial word.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        do_reset();
        saw_req = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (wr_req) saw_req = 1'b1;
        end
        check("no_req_after_reset", saw_req, 0);
        check("busy_after_reset", busy, 0);
        frame_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_frame(1'b1);
        drain();

        for (int f = 0; f < 25; f++) begin
            frame_bytes.delete();
            for (int i = 0; i < int'($urandom_range(1, 24)); i++) frame_bytes.push_back(8'($urandom));
            send_frame(1'b1);
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        // Address wrap on the instance based at 7FFFF.
        for (int i = 0; i < 8; i++) begin
            x_in_valid = 1'b1; x_in_data = 8'(i + 1); x_in_last = (i == 7);
            @(negedge clk);
        end
        x_in_valid = 1'b0; x_in_last = 1'b0;
        t = 0;
        while (x_frm.size() == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("wrap_words", x_seen.size(), 2);
        check("wrap_frames", x_frm.size(), 1);
        if (x_seen.size() >= 2) begin
            check("wrap_ad0", x_seen[0][50:32], 19'h7FFFF);
            check("wrap_data0", x_seen[0][31:0], 32'h04030201);
            check("wrap_ad1", x_seen[1][50:32], 19'h00000);
            check("wrap_data1", x_seen[1][31:0], 32'h08070605);
        end
        if (x_frm.size() >= 1) begin
            check("wrap_frame_base", x_frm[0][34:16], 19'h7FFFF);
            check("wrap_frame_len", x_frm[0][15:0], 16'd8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_rx_mem_writer.md
Name: eth_rx_mem_writer

Overview:
Upstream feeder for the SDRAM controller's write port. It accepts a byte stream from the Ethernet RX path and packs the bytes little-endian into 32-bit words. Words are buffered in a small FIFO and issued one at a time as wr_req/wr_ad/wr_data, with sequential addresses. Each completed frame's base address and byte length are reported so the packet handler can locate the frame in memory.

Parameters:
BASE_AD, 19'd0, word address of the first word after reset
FIFO_DEPTH, 8, word FIFO entries; power of 2, at least 2
WR_HOLD, 4, cycles that wr_ad/wr_data stay stable after wr_granted before the next word is presented

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_last  in  1  marks the final byte of a frame; qualified by in_valid
in_ready  out  1  byte accepted on a clock edge where in_valid && in_ready
wr_req  out  1  write request to the SDRAM controller
wr_ad  out  19  write word address: [18:8] row, [7:0] column
wr_data  out  32  write data
wr_granted  in  1  1-cycle grant pulse from the SDRAM controller
frame_done  out  1  1-cycle pulse when a frame's last word has completed its hold
frame_base  out  19  word address of the first word of that frame; valid with frame_done
frame_len  out  16  byte count of that frame; valid with frame_done
busy  out  1  high when the FIFO is non-empty, a word is partially packed, or the write FSM is not in IDLE

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. All state clears on reset.
- Reset values: wr_req=0, wr_ad=BASE_AD, wr_data=0, frame_done=0, frame_base=BASE_AD, frame_len=0, in_ready=1, busy=0.
- Reset mid-frame drops the partial word, the FIFO contents, and any outstanding request. The next address reverts to BASE_AD.
- Packer:
  - byte k of a word goes to bits [8k+7:8k]; k = 0..3.
  - A word is pushed on the edge that accepts its 4th byte, or on the edge that accepts an in_last byte.
  - A partial last word is zero-padded.
  - Each FIFO entry holds {last flag, nbytes (1..4), data[31:0]}.
- in_ready = (fifo_count < FIFO_DEPTH), registered. It must never permit a push into a full FIFO.
- A simultaneous push and pop leaves fifo_count unchanged.
- Write FSM has three states: IDLE, REQ, HOLD.
  - IDLE: if the FIFO is non-empty, load wr_ad = next_ad and wr_data = head, set wr_req=1, go to REQ.
  - REQ: wr_req, wr_ad and wr_data are held stable. On wr_granted: pop the FIFO, set wr_req=0, next_ad += 1 (wraps modulo 2^19, 7FFFF -> 00000), load hold counter = WR_HOLD, go to HOLD. wr_req never drops without a grant.
  - HOLD: wr_ad and wr_data are held. Decrement the counter; go to IDLE when it reaches 0 (WR_HOLD cycles in HOLD).
- Frame accounting:
  - On each grant, len_acc += nbytes.
  - If the granted entry is the first word of a frame, latch its address into base_acc.
  - On HOLD exit for an entry with the last flag set: pulse frame_done for 1 cycle, frame_base = base_acc, frame_len = len_acc, then clear len_acc.
  - The next frame's base is the address that follows the last word.
- frame_len saturates at 16'hFFFF.
- Latency: wr_req rises 2 edges after the edge that pushes the word into an empty FIFO with the FSM idle.
- in_last together with the 4th byte of a word produces a single push with nbytes=4; no empty word is pushed.
- in_valid with in_ready=0: the byte is not consumed. The upstream must hold it.

Test Plan:
- 4-byte frame 11,22,33,44 with last, grant 3 cycles after wr_req -> wr_req high, wr_ad=0, wr_data=32'h44332211. Then frame_done with frame_base=0, frame_len=4, exactly WR_HOLD cycles after the grant.
- 6-byte frame 01..06 -> words 32'h04030201 at ad 0 and 32'h00000605 at ad 1; frame_len=6.
- Grant withheld for 50 cycles during a 40-byte frame (FIFO_DEPTH=8) -> in_ready drops after 32 bytes, no byte lost, wr_ad/wr_data stable throughout REQ. After grants resume, all 10 words are written in order.
- Two back-to-back frames of 5 and 8 bytes -> frame_done #1 base=0 len=5; frame_done #2 base=2 len=8.
- Reset after 3 bytes of a frame -> no wr_req. A new 4-byte frame is written to BASE_AD.
- BASE_AD=19'h7FFFF, 8-byte frame -> writes at 7FFFF then 00000; frame_base=7FFFF, frame_len=8.
